// File: rtl/timeslot_scheduler.sv
// timeslot_scheduler
//   Shares one slow-rate time resource between N_REQ requesters on the 1 MHz
//   domain. A built-in prescaler produces coherent single-cycle tick enables
//   (tick_100k every DIV_FAST cycles, tick_10k every DIV_FAST*DIV_SLOW cycles,
//   always coincident with a tick_100k). A round-robin arbiter hands out slots
//   of SLOT_TICKS tick_100k periods, starting only on a tick_10k edge.
//
//   Ports:
//     clock1M        in   system clock, 1 MHz
//     reset          in   asynchronous, active-high reset
//     enable         in   0 = prescaler cleared and held, no new grants
//     req            in   level request per requester
//     gnt            out  one-hot grant, all-zero when idle
//     tick_100k      out  one-cycle pulse every DIV_FAST cycles
//     tick_10k       out  one-cycle pulse every DIV_FAST*DIV_SLOW cycles
//     slot_active    out  high while any gnt bit is high
//     slot_owner     out  index of current/last owner
//     slot_remaining out  tick_100k periods left in current slot
//
//   Build option:
//     TSS_PRIO0_EN   requester 0 wins every arbitration it takes part in;
//                    the round-robin pointer is left untouched when it does.
module timeslot_scheduler #(
  parameter int N_REQ      = 4,
  parameter int DIV_FAST   = 10,
  parameter int DIV_SLOW   = 10,
  parameter int SLOT_TICKS = 5
) (
  input  logic                     clock1M,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         gnt,
  output logic                     tick_100k,
  output logic                     tick_10k,
  output logic                     slot_active,
  output logic [$clog2(N_REQ)-1:0] slot_owner,
  output logic [7:0]               slot_remaining
);

  localparam int OW = $clog2(N_REQ);
  localparam int FW = (DIV_FAST > 1) ? $clog2(DIV_FAST) : 1;
  localparam int SW = (DIV_SLOW > 1) ? $clog2(DIV_SLOW) : 1;
  localparam logic [FW-1:0] FAST_MAX = FW'(DIV_FAST - 1);
  localparam logic [SW-1:0] SLOW_MAX = SW'(DIV_SLOW - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_q, state_d;
  logic [FW-1:0]      fast_q, fast_d;
  logic [SW-1:0]      slow_q, slow_d;
  logic               tick_100k_q, tick_10k_q;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic               active_q;
  logic [OW-1:0]      owner_q, owner_d;
  logic [OW-1:0]      rr_q, rr_d;
  logic [7:0]         rem_q, rem_d;
  logic               wrap_fast, wrap_slow;
  logic [OW-1:0]      winner;

  // First set request bit strictly after ptr, wrapping modulo N_REQ. The loop
  // runs from the farthest candidate down so the nearest one is kept last.
  function automatic logic [OW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                            input logic [OW-1:0]    ptr);
    logic [OW-1:0] pick;
    logic [OW-1:0] idx;
    pick = ptr;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = OW'((int'(ptr) + i) % N_REQ);
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

  // Wrap conditions are combinational so the tick registers and the FSM act
  // on the same edge that raises the registered tick outputs.
  assign wrap_fast = enable && (fast_q == FAST_MAX);
  assign wrap_slow = wrap_fast && (slow_q == SLOW_MAX);

  always_comb begin
    fast_d = fast_q;
    slow_d = slow_q;
    if (!enable) begin
      fast_d = '0;
      slow_d = '0;
    end else if (wrap_fast) begin
      fast_d = '0;
      slow_d = wrap_slow ? '0 : slow_q + 1'b1;
    end else begin
      fast_d = fast_q + 1'b1;
    end
  end

`ifdef TSS_PRIO0_EN
  assign winner = req[0] ? '0 : rr_pick(req, rr_q);
`else
  assign winner = rr_pick(req, rr_q);
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (wrap_slow && (|req)) begin
          gnt_d   = N_REQ'(1) << winner;
          owner_d = winner;
          rem_d   = 8'(SLOT_TICKS);
          state_d = GRANT;
`ifdef TSS_PRIO0_EN
          if (!req[0]) rr_d = winner;
`else
          rr_d    = winner;
`endif
        end
      end
      GRANT: begin
        // Early release takes precedence and also covers a release that
        // lands on the expiry edge: one transition to IDLE either way.
        if (!req[owner_q]) begin
          gnt_d   = '0;
          rem_d   = '0;
          state_d = IDLE;
        end else if (wrap_fast) begin
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock1M or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      fast_q      <= '0;
      slow_q      <= '0;
      tick_100k_q <= 1'b0;
      tick_10k_q  <= 1'b0;
      gnt_q       <= '0;
      active_q    <= 1'b0;
      owner_q     <= '0;
      rr_q        <= OW'(N_REQ - 1);
      rem_q       <= '0;
    end else begin
      state_q     <= state_d;
      fast_q      <= fast_d;
      slow_q      <= slow_d;
      tick_100k_q <= wrap_fast;
      tick_10k_q  <= wrap_slow;
      gnt_q       <= gnt_d;
      active_q    <= |gnt_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      rem_q       <= rem_d;
    end
  end

  assign gnt            = gnt_q;
  assign tick_100k      = tick_100k_q;
  assign tick_10k       = tick_10k_q;
  assign slot_active    = active_q;
  assign slot_owner     = owner_q;
  assign slot_remaining = rem_q;

endmodule
